// File: rtl/hdb3_encoder.sv
// Binary-to-HDB3 line encoder: 4-deep tag pipeline with 000V/B00V substitution,
// emitting registered dual-rail {plus, minus} symbols.
module hdb3_encoder (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_data,
    output logic [1:0] o_hdb3_code,
    output logic       o_valid,
    output logic       o_viol
);

    typedef enum logic [1:0] {
        T_ZERO = 2'd0,
        T_MARK = 2'd1,
        T_B    = 2'd2,
        T_V    = 2'd3
    } tag_t;

    tag_t       r_s0, r_s1, r_s2, r_s3;
    logic [1:0] r_zero_cnt;
    logic       r_parity;   // 1 = odd number of pulses since the last V
    logic       r_last;     // 1 = last pulse was plus
    logic [2:0] r_fill;

    logic       w_subst;
    tag_t       w_in_tag;
    tag_t       w_s3_next;
    logic [1:0] w_code;
    logic       w_viol;
    logic       w_last_next;
    logic       w_parity_next;
    logic [1:0] w_zero_cnt_next;

    always_comb begin
        w_code        = 2'b00;
        w_viol        = 1'b0;
        w_last_next   = r_last;
        w_parity_next = r_parity;
        case (r_s3)
            T_MARK, T_B: begin
                w_code        = r_last ? 2'b01 : 2'b10;
                w_last_next   = ~r_last;
                w_parity_next = ~r_parity;
            end
            T_V: begin
                w_code        = r_last ? 2'b10 : 2'b01;
                w_viol        = 1'b1;
                w_parity_next = 1'b0;
            end
            default: ;
        endcase

        // The parity after emitting old s3 is the effective parity for a
        // substitution decided on this same edge.
        w_subst   = !i_data && (r_zero_cnt == 2'd3);
        w_in_tag  = w_subst ? T_V : (i_data ? T_MARK : T_ZERO);
        w_s3_next = (w_subst && !w_parity_next) ? T_B : r_s2;

        if (i_data || w_subst) begin
            w_zero_cnt_next = 2'd0;
        end else begin
            w_zero_cnt_next = r_zero_cnt + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s0        <= T_ZERO;
            r_s1        <= T_ZERO;
            r_s2        <= T_ZERO;
            r_s3        <= T_ZERO;
            r_zero_cnt  <= '0;
            r_parity    <= 1'b0;
            r_last      <= 1'b0;
            r_fill      <= '0;
            o_hdb3_code <= '0;
            o_valid     <= 1'b0;
            o_viol      <= 1'b0;
        end else if (i_en) begin
            r_s0        <= w_in_tag;
            r_s1        <= r_s0;
            r_s2        <= r_s1;
            r_s3        <= w_s3_next;
            r_zero_cnt  <= w_zero_cnt_next;
            r_parity    <= w_parity_next;
            r_last      <= w_last_next;
            if (r_fill != 3'd4) begin
                r_fill <= r_fill + 3'd1;
            end
            o_hdb3_code <= w_code;
            o_valid     <= (r_fill >= 3'd3);
            o_viol      <= w_viol;
        end
    end

    always_ff @(posedge i_clk) begin
        assert (o_hdb3_code != 2'b11);
    end

endmodule

// File: tb/tb_hdb3_encoder.sv
// Directed scoreboard bench for hdb3_encoder plus a random stream checked by
// an independent HDB3 decoder and line-code property checks.
module tb_hdb3_encoder;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_en = 1'b0;
    logic       i_data = 1'b0;
    logic [1:0] o_hdb3_code;
    logic       o_valid;
    logic       o_viol;

    int errors = 0;
    int checks = 0;
    int sb_idx = 0;

    logic [3:0] exp_q[$];   // {code, valid, viol} expected after each edge

    hdb3_encoder dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_data      (i_data),
        .o_hdb3_code (o_hdb3_code),
        .o_valid     (o_valid),
        .o_viol      (o_viol)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per clock edge in directed phases
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({o_hdb3_code, o_valid, o_viol} !== e) begin
                    errors++;
                    $display("FAIL sb[%0d] code/valid/viol got %b/%b/%b expected %b/%b/%b",
                             sb_idx, o_hdb3_code, o_valid, o_viol, e[3:2], e[1], e[0]);
                end
                sb_idx++;
            end
        end
    end

    task automatic step(input logic rst, input logic en, input logic d,
                        input logic [1:0] ecode, input logic evalid, input logic eviol);
        @(negedge clk);
        i_rst  = rst;
        i_en   = en;
        i_data = d;
        exp_q.push_back({ecode, evalid, eviol});
    endtask

    task automatic do_reset(input logic en, input logic d);
        step(1'b1, en, d, 2'b00, 1'b0, 1'b0);
    endtask

    // Feed n bits (item k at bits[k-1]) after a reset. Output after accept k is
    // fill (00) for k<=4, else symbol k-5 from syms/viols. gap idle cycles follow
    // every accept, during which outputs must hold.
    task automatic run_vec(input logic [31:0] bits, input int n,
                           input logic [63:0] syms, input logic [31:0] viols,
                           input int gap);
        logic [1:0] c;
        logic       va;
        logic       vi;
        for (int k = 1; k <= n; k++) begin
            if (k <= 4) begin
                c  = 2'b00;
                va = (k == 4);
                vi = 1'b0;
            end else begin
                c  = syms[2*(k-5) +: 2];
                va = 1'b1;
                vi = viols[k-5];
            end
            step(1'b0, 1'b1, bits[k-1], c, va, vi);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'b0, ~bits[k-1], c, va, vi);
            end
        end
    endtask

    task automatic drain();
        int budget;
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic random_stream(input int nbits);
        logic in_bits[$];
        int   dec[$];
        bit   have_pulse;
        bit   last_pol;
        bit   have_v;
        bit   last_v_pol;
        int   zrun;
        bit   pol;
        int   j;
        have_pulse = 0;
        last_pol   = 0;
        have_v     = 0;
        last_v_pol = 0;
        zrun       = 0;
        for (int k = 1; k <= nbits; k++) begin
            @(negedge clk);
            i_rst  = 1'b0;
            i_en   = 1'b1;
            i_data = ($urandom_range(0, 2) == 0);
            in_bits.push_back(i_data);
            @(posedge clk);
            #1;
            if (k > 4) begin
                checks++;
                if (o_hdb3_code == 2'b11) begin
                    errors++;
                    $display("FAIL rnd_no11 k=%0d got 11 expected not 11", k);
                end
                if (o_hdb3_code == 2'b00) begin
                    zrun++;
                    dec.push_back(0);
                    checks++;
                    if (zrun >= 4 || o_viol !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_zero k=%0d zero_run=%0d viol=%b expected run<4 viol=0",
                                 k, zrun, o_viol);
                    end
                end else begin
                    pol  = (o_hdb3_code == 2'b10);
                    zrun = 0;
                    if (have_pulse && pol == last_pol) begin
                        checks++;
                        if (o_viol !== 1'b1 || (have_v && pol == last_v_pol)) begin
                            errors++;
                            $display("FAIL rnd_v k=%0d viol=%b pol=%b prev_v_pol=%b expected viol=1 alternating",
                                     k, o_viol, pol, last_v_pol);
                        end
                        have_v     = 1;
                        last_v_pol = pol;
                        for (int b = 1; b <= 3; b++) begin
                            if (dec.size() >= b) dec[dec.size()-b] = 0;
                        end
                        dec.push_back(0);
                    end else begin
                        checks++;
                        if (o_viol !== 1'b0) begin
                            errors++;
                            $display("FAIL rnd_mark k=%0d viol=%b expected 0", k, o_viol);
                        end
                        dec.push_back(1);
                    end
                    have_pulse = 1;
                    last_pol   = pol;
                end
                if (dec.size() >= 4) begin
                    j = dec.size() - 4;
                    checks++;
                    if (dec[j] != int'(in_bits[j])) begin
                        errors++;
                        $display("FAIL rnd_decode bit=%0d got %0d expected %0d", j, dec[j], in_bits[j]);
                    end
                end
            end
        end
    endtask

    initial begin
        // Reset state
        do_reset(1'b0, 1'b0);
        drain();

        // 1 0000 1: 000V after odd parity
        do_reset(1'b0, 1'b0);
        run_vec(32'h21, 10, 64'h602, 32'h10, 0);
        drain();

        // 8 zeros: two B00V groups, with outputs held over idle cycles
        do_reset(1'b0, 1'b0);
        run_vec(32'h0, 12, 64'h4182, 32'h88, 2);
        drain();

        // 1 1 0000: B00V after even parity
        do_reset(1'b0, 1'b0);
        run_vec(32'h3, 10, 64'h826, 32'h20, 0);
        drain();

        // 1 0 1 with strobe gaps of 3
        do_reset(1'b0, 1'b0);
        run_vec(32'h5, 7, 64'h12, 32'h0, 3);
        drain();

        // Reset mid zero run, asserted together with i_en and a 1 on i_data
        do_reset(1'b0, 1'b0);
        run_vec(32'h1, 6, 64'h2, 32'h0, 0);
        do_reset(1'b1, 1'b1);
        run_vec(32'h1, 5, 64'h2, 32'h0, 0);
        drain();

        // Random stream against an independent decoder
        do_reset(1'b0, 1'b0);
        drain();
        random_stream(10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdb3_encoder.md
# hdb3_encoder

Binary-to-HDB3 line encoder feeding the HDB3 decode stage. Takes one NRZ data bit per enabled clock and produces the dual-rail ternary code `{plus, minus}` that the decoder consumes. Runs of four zeros are replaced by 000V or B00V, with violation and bipolar polarities tracked so that the DC balance rules of HDB3 hold. The block has a fixed 4-bit look-ahead pipeline, and every output symbol is registered.

## Interface
- No parameters. The look-ahead depth is fixed at 4, as set by the HDB3 rule.
- `i_clk` in 1: single clock; every register is rising-edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_en` in 1: bit strobe. `i_data` is accepted and the pipeline advances only on edges where `i_en`=1.
- `i_data` in 1: NRZ data bit.
- `o_hdb3_code` out 2: registered symbol.
  - bit[1] = plus pulse, bit[0] = minus pulse.
  - 00 = zero.
  - 11 is never driven.
- `o_valid` out 1: high once the pipeline holds 4 real input bits.
- `o_viol` out 1: high while the current `o_hdb3_code` is a V symbol.

## Operation
- **Pipeline:** stages s0..s3, each holding a 2-bit tag: ZERO, MARK, B or V. s0 is newest, s3 is oldest. On an accept:
  - s3 is encoded into the output registers.
  - Stages shift s0→s1→s2→s3.
  - The input tag enters s0: MARK if `i_data`=1, else ZERO.
- **zero_cnt (0..3):** counts consecutive accepted zeros.
  - Cleared by an accepted 1.
  - Cleared by a substitution.
- **Substitution:** happens when `i_data`=0 and zero_cnt==3. On that accept:
  - The incoming tag is V.
  - The tag shifting s2→s3 becomes B if the effective parity is even; otherwise it stays ZERO.
  - zero_cnt is cleared to 0, so windows never overlap.
- **Effective parity:** computed from the parity register and the old s3 (the symbol being emitted on the same edge):
  - old s3 = V: parity is even.
  - old s3 = MARK or B: parity is the parity register inverted.
  - Otherwise: parity is the parity register.
- **Parity register:** updated from the emitted tag.
  - MARK or B: toggles.
  - V: clears to even.
  - ZERO: holds.
- **Polarity register (last):** records the polarity of the last pulse emitted.
  - MARK or B is emitted with the opposite polarity of last, and last is updated.
  - V is emitted with the same polarity as last, and last is unchanged.
  - ZERO is emitted as 00.
- **Fill counter (0..4):** counts accepts after reset. `o_valid` goes to 1 on the 4th accept and stays high until reset.
- **Reset values:**
  - All stages ZERO.
  - zero_cnt = 0.
  - Parity register even.
  - last = minus, so the first pulse after reset is plus.
  - Fill counter = 0.
  - `o_hdb3_code` = 00, `o_valid` = 0, `o_viol` = 0.
- **During fill:** stages that have not been loaded with real bits emit as ZERO. They do not count toward zero_cnt.

## Timing
- **Latency:** the bit accepted on accept n appears on `o_hdb3_code` after accept n+4. With `i_en` held high, this is 4 clocks.
- **Hold behaviour:** outputs change only on accepting edges. When `i_en`=0, every register holds, including `o_viol`.
- **Same-edge events:** the output encode, the parity/polarity update and the substitution decision all occur on one edge. The effective-parity rule above is what resolves them; there is no extra bubble.
- **Reset priority:** `i_rst` overrides `i_en`. Reset asserted mid-stream discards pipeline contents, and the next output is 00 with `o_valid`=0 for 4 accepts.
- **Long zero runs:** a run of 4k zeros produces k substitutions. Any 1–3 trailing zeros pass through as ZERO.
- **Assertion:** `o_hdb3_code` is never 11.

## Test plan
1. Reset, then `i_en`=1 with `i_data`=1,0,0,0,0,1 followed by zeros. After 4 fill cycles, codes are 10,00,00,00,10,01. `o_viol`=1 only on the fifth symbol (000V, odd parity).
2. Reset, then 8 zeros. Codes are 10,00,00,10,01,00,00,01 (two B00V groups of alternating polarity). `o_viol`=1 on symbols 4 and 8.
3. Reset, then 1,1,0,0,0,0. Codes are 10,01,10,00,00,10 (B00V after even parity).
4. Input 1,0,1 with `i_en` dropped for 3 cycles between bits. The output and `o_valid` freeze while `i_en`=0. The symbol sequence is identical to the ungated run: 10,00,01.
5. Assert `i_rst` for 1 cycle in the middle of a 0000 run. Next cycle `o_hdb3_code`=00 and `o_valid`=0. A following 1 emits 10 four accepts later.
6. Random 10k-bit stream fed through this block into the decode stage. The decoded output equals the input delayed. Also checked: no 11 symbols, no four consecutive 00 symbols, and consecutive V symbols alternate polarity.
